// File: rtl/lpc_prodcons_pkg.sv
// Shared constants and FSM state types for the LPC producer/consumer AXI4-Lite slave.
package lpc_prodcons_pkg;

    // Register indices as decoded from addr[3:2]
    localparam logic [1:0] ADDR_SCRATCH0  = 2'd0;
    localparam logic [1:0] ADDR_SCRATCH1  = 2'd1;
    localparam logic [1:0] ADDR_MBOX_DATA = 2'd2;
    localparam logic [1:0] ADDR_MBOX_STAT = 2'd3;

    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_OVF_BIT   = 24;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

endpackage

// File: rtl/lpc_prodcons_axil_slave_if.sv
// AXI4-Lite bus bundle for the S00_AXI port of the producer/consumer slave.
interface lpc_prodcons_axil_slave_if #(parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/lpc_prodcons_fifo.sv
// Show-ahead synchronous FIFO; a push while full is ignored, head reads 0 when empty.
module lpc_prodcons_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees room
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/lpc_prodcons_axil_slave.sv
// AXI4-Lite register block: two scratch registers plus a mailbox FIFO drained by the LPC side.
// Optional macro LPC_PRODCONS_SLVERR_EN: SLVERR on overflowing push or unaligned write.
module lpc_prodcons_axil_slave
    import lpc_prodcons_pkg::*;
#(
    parameter int FIFO_DEPTH         = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    lpc_prodcons_axil_slave_if.slave        s00_axi,
    output logic [31:0]                     m_data,
    output logic                            m_valid,
    input  logic                            m_ready
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_t                      wr_state;
    rd_state_t                      rd_state;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  aw_addr_q;
    logic [31:0]                    w_data_q;
    logic [3:0]                     w_strb_q;
    logic [31:0]                    scratch0;
    logic [31:0]                    scratch1;
    logic [31:0]                    last_push;
    logic                           overflow;
    logic                           aw_hs;
    logic                           w_hs;
    logic                           ar_hs;
    logic                           commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  c_addr;
    logic [31:0]                    c_data;
    logic [3:0]                     c_strb;
    logic                           c_err_addr;
    logic [1:0]                     c_resp;
    logic                           push;
    logic                           ovf_set;
    logic                           ovf_clr;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [CNT_W-1:0]               fifo_count;
    logic [31:0]                    stat_word;
    logic [31:0]                    rd_mux;
    logic                           unused_bits;

    assign aw_hs = s00_axi.awvalid & s00_axi.awready;
    assign w_hs  = s00_axi.wvalid & s00_axi.wready;
    assign ar_hs = s00_axi.arvalid & s00_axi.arready;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr, s00_axi.araddr};

    // The commit happens on whichever edge captures the second of the AW/W beats
    always_comb begin
        commit = 1'b0;
        c_addr = s00_axi.awaddr;
        c_data = s00_axi.wdata;
        c_strb = s00_axi.wstrb;
        case (wr_state)
            WR_IDLE:    commit = aw_hs & w_hs;
            WR_HAVE_AW: begin
                commit = w_hs;
                c_addr = aw_addr_q;
            end
            WR_HAVE_W:  begin
                commit = aw_hs;
                c_data = w_data_q;
                c_strb = w_strb_q;
            end
            default:    commit = 1'b0;
        endcase
    end

`ifdef LPC_PRODCONS_SLVERR_EN
    assign c_err_addr = (c_addr[1:0] != 2'b00);
`else
    assign c_err_addr = 1'b0;
`endif

    assign push    = commit & ~c_err_addr & (c_addr[3:2] == ADDR_MBOX_DATA);
    assign ovf_set = push & fifo_full;
    assign ovf_clr = commit & ~c_err_addr & (c_addr[3:2] == ADDR_MBOX_STAT) & c_data[STAT_OVF_BIT];

`ifdef LPC_PRODCONS_SLVERR_EN
    assign c_resp = (c_err_addr | ovf_set) ? RESP_SLVERR : RESP_OKAY;
`else
    assign c_resp = RESP_OKAY;
`endif

    lpc_prodcons_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(32)) u_fifo (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .push      (push),
        .push_data (c_data),
        .full      (fifo_full),
        .pop       (m_valid & m_ready),
        .head      (m_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid = ~fifo_empty;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            scratch0  <= '0;
            scratch1  <= '0;
            last_push <= '0;
            overflow  <= 1'b0;
        end else begin
            if (commit && !c_err_addr) begin
                for (int i = 0; i < 4; i++) begin
                    if (c_strb[i] && c_addr[3:2] == ADDR_SCRATCH0) scratch0[8*i +: 8] <= c_data[8*i +: 8];
                    if (c_strb[i] && c_addr[3:2] == ADDR_SCRATCH1) scratch1[8*i +: 8] <= c_data[8*i +: 8];
                end
            end
            if (push && !fifo_full) last_push <= c_data;
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_state        <= WR_IDLE;
            s00_axi.awready <= 1'b0;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
            s00_axi.bresp   <= RESP_OKAY;
            aw_addr_q       <= '0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) aw_addr_q <= s00_axi.awaddr;
                    if (w_hs) begin
                        w_data_q <= s00_axi.wdata;
                        w_strb_q <= s00_axi.wstrb;
                    end
                    if (commit) begin
                        s00_axi.awready <= 1'b0;
                        s00_axi.wready  <= 1'b0;
                        s00_axi.bvalid  <= 1'b1;
                        s00_axi.bresp   <= c_resp;
                        wr_state        <= WR_RESP;
                    end else if (aw_hs) begin
                        s00_axi.awready <= 1'b0;
                        s00_axi.wready  <= 1'b1;
                        wr_state        <= WR_HAVE_AW;
                    end else if (w_hs) begin
                        s00_axi.awready <= 1'b1;
                        s00_axi.wready  <= 1'b0;
                        wr_state        <= WR_HAVE_W;
                    end else begin
                        // Also brings the readies up on the first cycle out of reset
                        s00_axi.awready <= 1'b1;
                        s00_axi.wready  <= 1'b1;
                    end
                end
                WR_HAVE_AW, WR_HAVE_W: begin
                    if (commit) begin
                        s00_axi.awready <= 1'b0;
                        s00_axi.wready  <= 1'b0;
                        s00_axi.bvalid  <= 1'b1;
                        s00_axi.bresp   <= c_resp;
                        wr_state        <= WR_RESP;
                    end
                end
                default: begin
                    if (s00_axi.bready) begin
                        s00_axi.bvalid  <= 1'b0;
                        s00_axi.bresp   <= RESP_OKAY;
                        s00_axi.awready <= 1'b1;
                        s00_axi.wready  <= 1'b1;
                        wr_state        <= WR_IDLE;
                    end
                end
            endcase
        end
    end

    assign stat_word = {7'b0, overflow, 6'b0, fifo_full, fifo_empty, 16'(fifo_count)};

    always_comb begin
        rd_mux = '0;
        case (s00_axi.araddr[3:2])
            ADDR_SCRATCH0:  rd_mux = scratch0;
            ADDR_SCRATCH1:  rd_mux = scratch1;
            ADDR_MBOX_DATA: rd_mux = last_push;
            default:        rd_mux = stat_word;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_state        <= RD_IDLE;
            s00_axi.arready <= 1'b0;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rdata   <= '0;
            s00_axi.rresp   <= RESP_OKAY;
        end else begin
            s00_axi.rresp <= RESP_OKAY;
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        s00_axi.arready <= 1'b0;
                        s00_axi.rvalid  <= 1'b1;
                        s00_axi.rdata   <= rd_mux;
                        rd_state        <= RD_RESP;
                    end else begin
                        s00_axi.arready <= 1'b1;
                    end
                end
                default: begin
                    if (s00_axi.rready) begin
                        s00_axi.rvalid  <= 1'b0;
                        s00_axi.arready <= 1'b1;
                        rd_state        <= RD_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lpc_prodcons_axil_slave.sv
// Self-checking bench for lpc_prodcons_axil_slave against a queue-based register/mailbox model.
`timescale 1ns/1ps
module tb_lpc_prodcons_axil_slave;
    localparam int DEPTH = 16;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESETn;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

    lpc_prodcons_axil_slave_if #(.ADDR_W(4)) bus ();

    lpc_prodcons_axil_slave #(.FIFO_DEPTH(DEPTH), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .s00_axi_aclk    (tb_ACLK),
        .s00_axi_aresetn (tb_ARESETn),
        .s00_axi         (bus),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    // Reference model
    logic [31:0] mdl_scr [2];
    logic [31:0] mdl_q [$];
    logic        mdl_ovf;
    logic [31:0] mdl_last;

    function automatic void mdl_reset();
        mdl_scr[0] = '0;
        mdl_scr[1] = '0;
        mdl_q.delete();
        mdl_ovf  = 1'b0;
        mdl_last = '0;
    endfunction

    function automatic logic [1:0] mdl_write(logic [3:0] a, logic [31:0] d, logic [3:0] s);
        logic [1:0] r;
        int idx;
        r = 2'b00;
`ifdef LPC_PRODCONS_SLVERR_EN
        if (a[1:0] != 2'b00) return 2'b10;
`endif
        idx = int'(a[3:2]);
        if (idx < 2) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl_scr[idx][8*i +: 8] = d[8*i +: 8];
        end else if (idx == 2) begin
            if (mdl_q.size() == DEPTH) begin
                mdl_ovf = 1'b1;
`ifdef LPC_PRODCONS_SLVERR_EN
                r = 2'b10;
`endif
            end else begin
                mdl_q.push_back(d);
                mdl_last = d;
            end
        end else begin
            if (d[24]) mdl_ovf = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] mdl_read(logic [3:0] a);
        logic [31:0] v;
        v = '0;
        case (a[3:2])
            2'd0: v = mdl_scr[0];
            2'd1: v = mdl_scr[1];
            2'd2: v = mdl_last;
            default: begin
                v[15:0] = 16'(mdl_q.size());
                v[16]   = (mdl_q.size() == 0);
                v[17]   = (mdl_q.size() == DEPTH);
                v[24]   = mdl_ovf;
            end
        endcase
        return v;
    endfunction

    // Bus tasks: entered and left on a falling edge
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        resp = 2'bxx;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            @(negedge tb_ACLK); n++;
            if (hs_aw) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin bus.wvalid  = 1'b0; w_done  = 1; end
        end
        while (!bus.bvalid && n < 100) begin @(negedge tb_ACLK); n++; end
        if (!bus.bvalid) begin
            checks++; errors++;
            $display("FAIL wr_timeout addr=%h bvalid=%b required=1", a, bus.bvalid);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        end else begin
            resp = bus.bresp;
            @(negedge tb_ACLK);
        end
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        data = 'x; resp = 'x;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (!bus.arready && n < 50) begin @(negedge tb_ACLK); n++; end
        @(negedge tb_ACLK);
        bus.arvalid = 1'b0;
        while (!bus.rvalid && n < 100) begin @(negedge tb_ACLK); n++; end
        if (!bus.rvalid) begin
            checks++; errors++;
            $display("FAIL rd_timeout addr=%h rvalid=%b required=1", a, bus.rvalid);
        end else begin
            data = bus.rdata; resp = bus.rresp;
            @(negedge tb_ACLK);
        end
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = 0;
        while (m_valid && n < 2*DEPTH) begin
            checks++;
            if (mdl_q.size() == 0 || m_data !== mdl_q[0]) begin
                errors++;
                $display("FAIL %s_pop_data got=%h required=%h (model size %0d)", tag, m_data,
                         (mdl_q.size() != 0) ? mdl_q[0] : 32'h0, mdl_q.size());
            end
            m_ready = 1'b1;
            @(negedge tb_ACLK);
            m_ready = 1'b0;
            if (mdl_q.size() != 0) void'(mdl_q.pop_front());
            n++;
        end
        checks++;
        if (m_valid !== 1'b0 || mdl_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_empty m_valid=%b model_size=%0d required 0/0", tag, m_valid, mdl_q.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic [1:0] rr;
        tb_ARESETn = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            errors++; $display("FAIL rst_readies got=%b required=000", {bus.awready, bus.wready, bus.arready});
        end
        checks++;
        if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin
            errors++; $display("FAIL rst_resp got=%b required=000000", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp});
        end
        checks++;
        if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h required=0", bus.rdata); end
        checks++;
        if ({m_valid, m_data} !== 33'b0) begin
            errors++; $display("FAIL rst_stream got=%b/%h required=0/0", m_valid, m_data);
        end
        tb_ARESETn = 1'b1;
        mdl_reset();
        @(negedge tb_ACLK);
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            errors++; $display("FAIL rst_release_readies got=%b required=111", {bus.awready, bus.wready, bus.arready});
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i*4), rd, rr);
            checks++;
            if (rd !== mdl_read(4'(i*4)) || rr !== 2'b00) begin
                errors++; $display("FAIL rst_reg%0d got=%h/%b required=%h/00", i, rd, rr, mdl_read(4'(i*4)));
            end
        end
    endtask

    task automatic test_basic_rw();
        logic [31:0] rd; logic [1:0] r, rr;
        axi_write(4'h0, 32'h0101FFFF, 4'hF, r); void'(mdl_write(4'h0, 32'h0101FFFF, 4'hF));
        axi_read(4'h0, rd, rr);
        checks++;
        if (rd !== 32'h0101FFFF || rr !== 2'b00 || r !== 2'b00) begin
            errors++; $display("FAIL rw_scratch0 got=%h/%b/%b required=0101ffff/00/00", rd, rr, r);
        end
        axi_write(4'h4, 32'hABCD0001, 4'b0011, r); void'(mdl_write(4'h4, 32'hABCD0001, 4'b0011));
        axi_read(4'h4, rd, rr);
        checks++;
        if (rd !== 32'h00000001) begin errors++; $display("FAIL rw_strobe got=%h required=00000001", rd); end
    endtask

    task automatic test_channel_order();
        logic [31:0] rd; logic [1:0] rr;
        bus.awaddr = 4'h0; bus.awvalid = 1'b1; bus.bready = 1'b1;
        @(negedge tb_ACLK);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.awready !== 1'b0 || bus.bvalid !== 1'b0) begin
                errors++; $display("FAIL order_aw_wait%0d awready=%b bvalid=%b required=0/0", i, bus.awready, bus.bvalid);
            end
            if (i < 2) @(negedge tb_ACLK);
        end
        bus.wdata = 32'h5A5A1234; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        checks++;
        if (bus.wready !== 1'b1) begin errors++; $display("FAIL order_wready got=%b required=1", bus.wready); end
        @(negedge tb_ACLK);
        bus.wvalid = 1'b0;
        void'(mdl_write(4'h0, 32'h5A5A1234, 4'hF));
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
            errors++; $display("FAIL order_bvalid got=%b/%b required=1/00", bus.bvalid, bus.bresp);
        end
        @(negedge tb_ACLK);
        checks++;
        if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL order_bdone got=%b required=0", bus.bvalid); end
        axi_read(4'h0, rd, rr);
        checks++;
        if (rd !== mdl_read(4'h0)) begin errors++; $display("FAIL order_readback got=%h required=%h", rd, mdl_read(4'h0)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic [1:0] rr;
        bus.bready = 1'b0;
        bus.awaddr = 4'h0; bus.awvalid = 1'b1;
        bus.wdata = 32'h11112222; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge tb_ACLK);
        void'(mdl_write(4'h0, 32'h11112222, 4'hF));
        bus.awaddr = 4'h4; bus.wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d bvalid/awready/wready=%b%b%b required=100", i, bus.bvalid, bus.awready, bus.wready);
            end
            @(negedge tb_ACLK);
        end
        axi_read(4'h4, rd, rr);
        checks++;
        if (rd !== mdl_read(4'h4)) begin errors++; $display("FAIL bp_no_second got=%h required=%h", rd, mdl_read(4'h4)); end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        @(negedge tb_ACLK);
        checks++;
        if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b required=0", bus.bvalid); end
        axi_read(4'h0, rd, rr);
        checks++;
        if (rd !== 32'h11112222) begin errors++; $display("FAIL bp_first got=%h required=11112222", rd); end
    endtask

    task automatic test_mailbox();
        logic [31:0] rd; logic [1:0] r, rr;
        m_ready = 1'b0;
        drain_check("mb_pre");
        axi_write(4'hC, 32'h01000000, 4'hF, r); void'(mdl_write(4'hC, 32'h01000000, 4'hF));
        axi_write(4'h8, 32'hDEAD0011, 4'hF, r); void'(mdl_write(4'h8, 32'hDEAD0011, 4'hF));
        axi_write(4'h8, 32'hBEEF0011, 4'h0, r); void'(mdl_write(4'h8, 32'hBEEF0011, 4'h0));
        axi_read(4'hC, rd, rr);
        checks++;
        if (rd !== 32'h00000002) begin errors++; $display("FAIL mb_stat2 got=%h required=00000002", rd); end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hDEAD0011) begin
            errors++; $display("FAIL mb_head0 got=%b/%h required=1/dead0011", m_valid, m_data);
        end
        m_ready = 1'b1;
        @(negedge tb_ACLK);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hBEEF0011) begin
            errors++; $display("FAIL mb_head1 got=%b/%h required=1/beef0011", m_valid, m_data);
        end
        @(negedge tb_ACLK);
        m_ready = 1'b0;
        void'(mdl_q.pop_front()); void'(mdl_q.pop_front());
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mb_empty got=%b required=0", m_valid); end
        axi_read(4'hC, rd, rr);
        checks++;
        if (rd !== 32'h00010000) begin errors++; $display("FAIL mb_stat_empty got=%h required=00010000", rd); end
        axi_read(4'h8, rd, rr);
        checks++;
        if (rd !== 32'hBEEF0011) begin errors++; $display("FAIL mb_last got=%h required=beef0011", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, d; logic [1:0] r, rr, exp;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = $urandom;
            axi_write(4'h8, d, 4'($urandom), r);
            exp = mdl_write(4'h8, d, 4'hF);
            checks++;
            if (r !== exp) begin errors++; $display("FAIL ovf_bresp%0d got=%b required=%b", i, r, exp); end
        end
        axi_read(4'hC, rd, rr);
        checks++;
        if (rd !== 32'h01020010) begin errors++; $display("FAIL ovf_stat got=%h required=01020010", rd); end
        axi_write(4'hC, 32'h01000000, 4'hF, r); void'(mdl_write(4'hC, 32'h01000000, 4'hF));
        axi_read(4'hC, rd, rr);
        checks++;
        if (rd !== 32'h00020010) begin errors++; $display("FAIL ovf_w1c got=%h required=00020010", rd); end
        drain_check("ovf");
    endtask

    task automatic test_random();
        logic [31:0] rd, d; logic [1:0] r, rr, exp; logic [3:0] a;
        int op;
        m_ready = 1'b0;
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 4));
            d  = $urandom;
            case (op)
                0, 1, 2: begin
                    a = (op == 0) ? 4'(($urandom % 2) * 4) : (op == 1) ? 4'h8 : 4'hC;
                    axi_write(a, d, 4'($urandom), r);
                    exp = mdl_write(a, d, (a[3:2] < 2) ? dut.c_strb : 4'hF);
                    checks++;
                    if (r !== exp) begin errors++; $display("FAIL rnd_bresp it=%0d got=%b required=%b", it, r, exp); end
                end
                3: begin
                    a = 4'(($urandom % 4) * 4);
                    axi_read(a, rd, rr);
                    checks++;
                    if (rd !== mdl_read(a) || rr !== 2'b00) begin
                        errors++; $display("FAIL rnd_read it=%0d addr=%h got=%h required=%h", it, a, rd, mdl_read(a));
                    end
                end
                default: begin
                    checks++;
                    if (m_valid !== (mdl_q.size() != 0) || (m_valid && m_data !== mdl_q[0])) begin
                        errors++; $display("FAIL rnd_head it=%0d got=%b/%h model_size=%0d", it, m_valid, m_data, mdl_q.size());
                    end
                    if (m_valid) begin
                        m_ready = 1'b1;
                        @(negedge tb_ACLK);
                        m_ready = 1'b0;
                        if (mdl_q.size() != 0) void'(mdl_q.pop_front());
                    end
                end
            endcase
        end
        drain_check("rnd");
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic [1:0] r, rr;
        m_ready = 1'b0;
        axi_write(4'h0, 32'hCAFEF00D, 4'hF, r); void'(mdl_write(4'h0, 32'hCAFEF00D, 4'hF));
        axi_write(4'h8, 32'h12345678, 4'hF, r); void'(mdl_write(4'h8, 32'h12345678, 4'hF));
        bus.awaddr = 4'h0; bus.awvalid = 1'b1; bus.bready = 1'b1;
        @(negedge tb_ACLK);
        bus.awvalid = 1'b0;
        #2 tb_ARESETn = 1'b0;
        #1;
        checks++;
        if (bus.bvalid !== 1'b0 || m_valid !== 1'b0 || bus.awready !== 1'b0) begin
            errors++; $display("FAIL midrst_async bvalid/m_valid/awready=%b%b%b required=000", bus.bvalid, m_valid, bus.awready);
        end
        repeat (2) @(negedge tb_ACLK);
        tb_ARESETn = 1'b1;
        mdl_reset();
        @(negedge tb_ACLK);
        checks++;
        if (bus.bvalid !== 1'b0 || {bus.awready, bus.wready} !== 2'b11) begin
            errors++; $display("FAIL midrst_release bvalid=%b readies=%b required=0/11", bus.bvalid, {bus.awready, bus.wready});
        end
        axi_read(4'h0, rd, rr);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_scratch0 got=%h required=0", rd); end
        axi_read(4'hC, rd, rr);
        checks++;
        if (rd !== 32'h00010000) begin errors++; $display("FAIL midrst_stat got=%h required=00010000", rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        m_ready = 1'b0;
        tb_ARESETn = 1'b0;
        mdl_reset();
        @(negedge tb_ACLK);
        test_reset();
        test_basic_rw();
        test_channel_order();
        test_backpressure();
        test_mailbox();
        test_overflow();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
